// File: rtl/axinmerge.sv
// axinmerge: packet-level N:1 round-robin merge of AXIN streams with a registered output stage and one-hot source tag
module axinmerge #(
  parameter int NIN = 4,
  parameter int DW = 64,
  parameter int WBITS = $clog2(DW/8),
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NIN-1:0]     i_cfg_active,
  input  logic [NIN-1:0]     S_VALID,
  output logic [NIN-1:0]     S_READY,
  input  logic [NIN*DW-1:0]  S_DATA,
  input  logic [NIN*WBITS-1:0] S_BYTES,
  input  logic [NIN-1:0]     S_LAST,
  input  logic [NIN-1:0]     S_ABORT,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic [DW-1:0]      M_DATA,
  output logic [WBITS-1:0]   M_BYTES,
  output logic               M_LAST,
  output logic               M_ABORT,
  output logic [NIN-1:0]     M_PORT
);
  localparam int GW = $clog2(NIN);
  typedef enum logic {IDLE, GRANTED} state_t;
  state_t state;
  logic [GW-1:0] grant, last_grant, next_grant;
  logic [NIN-1:0] elig, m_port;
  logic any_elig, g_ready, g_abort, accept;
  logic m_valid, m_last, m_abort;
  logic [DW-1:0] m_data;
  logic [WBITS-1:0] m_bytes;
  assign elig = i_cfg_active & S_VALID & ~S_ABORT;
  // Scan from farthest to nearest so the nearest eligible source after last_grant wins
  always_comb begin
    next_grant = last_grant;
    any_elig = 1'b0;
    for (int i = NIN; i >= 1; i--)
      if (elig[(int'(last_grant) + i) % NIN]) begin
        next_grant = GW'((int'(last_grant) + i) % NIN);
        any_elig = 1'b1;
      end
  end
  assign g_ready = (state == GRANTED) && (!m_valid || M_READY);
  assign g_abort = (state == GRANTED) &&
                   (!i_cfg_active[grant] || (S_ABORT[grant] && (!S_VALID[grant] || g_ready)));
  assign accept = g_ready && S_VALID[grant] && !g_abort;
  always_comb begin
    S_READY = '0;
    for (int k = 0; k < NIN; k++)
      S_READY[k] = (state == GRANTED && grant == GW'(k)) ? g_ready
                 : (!i_cfg_active[k] || (S_VALID[k] && S_ABORT[k]));
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= GW'(NIN-1);
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_abort <= 1'b0;
      m_data <= '0;
      m_bytes <= '0;
      m_port <= '0;
    end else begin
      if (m_abort && (!m_valid || M_READY)) m_abort <= 1'b0;
      if (M_READY) m_valid <= 1'b0;
      if (state == IDLE) begin
        if (!m_abort && any_elig) begin
          grant <= next_grant;
          last_grant <= next_grant;
          state <= GRANTED;
        end
      end else if (g_abort) begin
        state <= IDLE;
        // a held LAST beat belongs to a completed packet and must survive
        if (!(m_valid && m_last)) begin
          m_valid <= 1'b0;
          m_abort <= 1'b1;
          m_port <= NIN'(1) << grant;
        end
      end else if (accept) begin
        m_valid <= 1'b1;
        m_data <= S_DATA[int'(grant)*DW +: DW];
        m_bytes <= S_BYTES[int'(grant)*WBITS +: WBITS];
        m_last <= S_LAST[grant];
        m_port <= NIN'(1) << grant;
        if (S_LAST[grant]) state <= IDLE;
      end
    end
  assign M_VALID = m_valid;
  assign M_ABORT = m_abort;
  assign M_PORT = m_port;
  assign M_DATA = (OPT_LOWPOWER && !m_valid) ? '0 : m_data;
  assign M_BYTES = (OPT_LOWPOWER && !m_valid) ? '0 : m_bytes;
  assign M_LAST = (OPT_LOWPOWER && !m_valid) ? 1'b0 : m_last;
endmodule

// File: tb/tb_axinmerge.sv
// tb_axinmerge: directed checks of the round-robin packet merger
module tb_axinmerge;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] cfg, sv, sr, sl, sa, mp;
  logic [63:0] sd;
  logic [3:0] sb;
  logic mv, mr, ml, ma;
  logic [15:0] md;
  logic [0:0] mb;
  int tests = 0, fails = 0;
  int npk[4], nb[4], pos[4], pk[4];
  int viol = 0, sr3_bad = 0;
  logic prev_hold = 1'b0;
  logic [15:0] prev_md = '0;
  logic [20:0] obs_q[$];
  localparam logic [20:0] E2 [8] = '{
    {4'b0001, 16'h0000, 1'b0}, {4'b0001, 16'h0001, 1'b1},
    {4'b0010, 16'h1000, 1'b0}, {4'b0010, 16'h1001, 1'b1},
    {4'b0100, 16'h2000, 1'b0}, {4'b0100, 16'h2001, 1'b1},
    {4'b0001, 16'h0100, 1'b0}, {4'b0001, 16'h0101, 1'b1}};
  always #5 clk = ~clk;
  axinmerge #(.NIN(4), .DW(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_cfg_active(cfg),
    .S_VALID(sv), .S_READY(sr), .S_DATA(sd), .S_BYTES(sb), .S_LAST(sl), .S_ABORT(sa),
    .M_VALID(mv), .M_READY(mr), .M_DATA(md), .M_BYTES(mb), .M_LAST(ml), .M_ABORT(ma), .M_PORT(mp));
  // output monitor: records delivered beats and flags data changing under stall
  always @(negedge clk) begin
    if (rst_n && prev_hold && (!mv || md !== prev_md)) viol++;
    prev_hold = rst_n && mv && !mr;
    prev_md = md;
    if (rst_n && mv && mr) obs_q.push_back({mp, md, ml});
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic rst_apply;
    rst_n = 1'b0;
    sv = '0; sa = '0; sl = '0; sd = '0; sb = '0; mr = 1'b1;
    for (int k = 0; k < 4; k++) begin npk[k] = 0; nb[k] = 1; pos[k] = 0; pk[k] = 0; end
    tick;
    tick;
    rst_n = 1'b1;
    obs_q.delete();
    viol = 0;
    sr3_bad = 0;
  endtask
  task automatic run(input int budget, input bit toggle);
    logic [3:0] acc;
    int c = 0;
    while (c < budget && (npk[0] + npk[1] + npk[2] + npk[3]) > 0) begin
      for (int k = 0; k < 4; k++) begin
        sv[k] = npk[k] > 0;
        sd[k*16 +: 16] = {4'(k), 4'(pk[k]), 8'(pos[k])};
        sl[k] = pos[k] == nb[k] - 1;
      end
      mr = toggle ? ~mr : 1'b1;
      @(negedge clk);
      acc = sv & sr;
      if (!cfg[3] && sv[3] && !sr[3]) sr3_bad++;
      tick;
      for (int k = 0; k < 4; k++)
        if (acc[k]) begin
          if (sl[k]) begin pos[k] = 0; pk[k]++; npk[k]--; end
          else pos[k]++;
        end
      c++;
    end
    chk("run_done", npk[0] + npk[1] + npk[2] + npk[3], 0);
    sv = '0; sl = '0; mr = 1'b1;
    repeat (3) tick;
  endtask
  initial begin
    cfg = 4'hF; mr = 1'b1; sv = '0; sa = '0; sl = '0; sd = '0; sb = '0;
    #12;
    chk("rst_mv", mv, 0); chk("rst_ma", ma, 0); chk("rst_mp", mp, 0);
    chk("rst_md", md, 0); chk("rst_ml", ml, 0); chk("rst_mb", mb, 0); chk("rst_sr", sr, 0);
    // 1: single 3-beat packet from src0
    rst_apply;
    sv[0] = 1'b1; sd[15:0] = 16'hA001;
    #1 chk("t1_idle_noready", sr[0], 0);
    tick;
    chk("t1_grant_ready", sr[0], 1); chk("t1_no_valid_yet", mv, 0);
    tick;
    chk("t1_mv_2cyc", mv, 1); chk("t1_port", mp, 4'b0001); chk("t1_d1", md, 16'hA001);
    sd[15:0] = 16'hA002;
    tick;
    chk("t1_d2", md, 16'hA002); chk("t1_l2", ml, 0);
    sd[15:0] = 16'hA003; sl[0] = 1'b1;
    tick;
    chk("t1_d3", md, 16'hA003); chk("t1_l3", ml, 1);
    sv[0] = 1'b0; sl[0] = 1'b0;
    tick;
    chk("t1_done", mv, 0); chk("t1_count", obs_q.size(), 3);
    // 2: three sources contend, round-robin order 0,1,2,0
    rst_apply;
    npk = '{2, 1, 1, 0}; nb = '{2, 2, 2, 2};
    run(60, 1'b0);
    chk("t2_count", obs_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_beat%0d", i), obs_q[i], E2[i]);
    // 3: src1 aborts with a non-last beat held
    rst_apply;
    sv[1] = 1'b1; sd[31:16] = 16'h1000;
    tick;
    sv[0] = 1'b1; sd[15:0] = 16'h0000; sl[0] = 1'b1;
    sv[2] = 1'b1; sd[47:32] = 16'h2000; sl[2] = 1'b1;
    tick;
    chk("t3_b1", md, 16'h1000);
    sd[31:16] = 16'h1001;
    tick;
    chk("t3_b2", md, 16'h1001);
    mr = 1'b0; sv[1] = 1'b0; sa[1] = 1'b1;
    tick;
    chk("t3_drop_mv", mv, 0); chk("t3_abort", ma, 1); chk("t3_abort_port", mp, 4'b0010);
    sa[1] = 1'b0;
    tick;
    chk("t3_abort_1cyc", ma, 0);
    tick;
    mr = 1'b1;
    #1 chk("t3_sr2", sr[2], 1); chk("t3_sr0", sr[0], 0);
    tick;
    chk("t3_next_src2", mp, 4'b0100); chk("t3_d2", md, 16'h2000); chk("t3_l2", ml, 1);
    sv[2] = 1'b0; sl[2] = 1'b0;
    tick;
    tick;
    chk("t3_then_src0", mp, 4'b0001);
    sv[0] = 1'b0; sl[0] = 1'b0;
    tick;
    // 4: inactive src3 is drained, never forwarded
    rst_apply;
    cfg = 4'b0111;
    npk = '{1, 0, 0, 3}; nb = '{2, 2, 2, 2};
    run(60, 1'b0);
    chk("t4_count", obs_q.size(), 2);
    chk("t4_b0", obs_q[0], {4'b0001, 16'h0000, 1'b0});
    chk("t4_b1", obs_q[1], {4'b0001, 16'h0001, 1'b1});
    chk("t4_sr3_always", sr3_bad, 0);
    cfg = 4'hF;
    // 5: toggling M_READY across a 5-beat packet
    rst_apply;
    npk = '{1, 0, 0, 0}; nb = '{5, 2, 2, 2};
    run(80, 1'b1);
    chk("t5_count", obs_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t5_beat%0d", i), obs_q[i], {4'b0001, 16'(i), i == 4});
    chk("t5_stable", viol, 0);
    // 6: reset mid-packet, then src0 wins first grant
    rst_apply;
    mr = 1'b0; sv[0] = 1'b1; sd[15:0] = 16'h6000;
    tick;
    tick;
    tick;
    chk("t6_held", mv, 1);
    rst_n = 1'b0;
    #1 chk("t6_rst_mv", mv, 0); chk("t6_rst_ma", ma, 0); chk("t6_rst_mp", mp, 0);
    sv[1] = 1'b1; sd[31:16] = 16'h6100;
    tick;
    rst_n = 1'b1; mr = 1'b1;
    tick;
    chk("t6_sr0", sr[0], 1); chk("t6_sr1", sr[1], 0);
    tick;
    chk("t6_port", mp, 4'b0001); chk("t6_data", md, 16'h6000);
    sv = '0;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
